// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encodings, instruction field layout
// and the reset/halt constants of the 16-bit pipeline.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0]   FETCH_HALT_OPC  = 5'b00000;
    localparam logic [INSTR_W-1:0] FETCH_NOP_INSTR = 16'h0800;
    localparam logic [PC_W-1:0]    FETCH_RESET_PC  = 16'h0000;

    typedef enum logic [1:0] {
        ST_REQ      = 2'd0,
        ST_WAIT_BUF = 2'd1,
        ST_HALT     = 2'd2
    } fetch_state_t;

    function automatic logic is_halt_opc(input logic [INSTR_W-1:0] instr,
                                         input logic [OPC_W-1:0]   halt_opc);
        return instr[OPC_MSB:OPC_LSB] == halt_opc;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction buffer feeding IF/ID; shows NOP_INSTR whenever empty.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_consume,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc_inc,
    output logic               o_vld,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc_inc
);

    logic               r_vld;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_inc;

    // Flush wins over load, load wins over consume (refill on the draining edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld    <= 1'b0;
            r_instr  <= NOP_INSTR;
            r_pc_inc <= '0;
        end else begin
            if (i_load) begin
                r_instr  <= i_instr;
                r_pc_inc <= i_pc_inc;
            end
            if (i_flush)
                r_vld <= 1'b0;
            else if (i_load)
                r_vld <= 1'b1;
            else if (i_consume)
                r_vld <= 1'b0;
        end
    end

    assign o_vld    = r_vld;
    assign o_instr  = r_vld ? r_instr : NOP_INSTR;
    assign o_pc_inc = r_pc_inc;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, one-at-a-time imem reads, redirect squash and HALT.
// Optional macro FETCH_ALIGN_CHECK_EN enables the odd-PC alignment trap (err output).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = FETCH_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = FETCH_NOP_INSTR,
    parameter logic [OPC_W-1:0]   HALT_OPC  = FETCH_HALT_OPC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc_inc,
    output logic               stall_n,
    output logic               halted,
    output logic               err,
    output logic [1:0]         o_dbg_state
);

    // imem handshake: imem_req is a level; a read completes in any cycle with
    // imem_req & imem_ready, and imem_addr is held stable while imem_req & ~imem_ready.

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_hold_addr;
    logic            r_squash;
    logic            r_halted;

    logic            w_buf_vld;
    logic            w_load;
    logic            w_outstanding;
    logic            w_misalign;
    logic [PC_W-1:0] w_pc_next;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_err;

    assign w_misalign = (r_state == ST_REQ) & r_pc[0] & ~r_squash;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_misalign & ~redirect)
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign w_misalign = 1'b0;
    assign err        = 1'b0;
`endif

    assign stall_n   = w_buf_vld & ~hold & ~redirect;
    // A squashed read keeps the bus until its data returns, regardless of FSM state.
    assign imem_req  = ~rst & (r_squash |
                       ((r_state != ST_HALT) & ~w_misalign & (~w_buf_vld | stall_n)));
    assign imem_addr = r_squash ? r_hold_addr : r_pc;

    assign w_outstanding = imem_req & ~imem_ready;
    assign w_load        = imem_req & imem_ready & ~r_squash & ~redirect;
    assign w_pc_next     = r_pc + 16'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_PC;
            r_hold_addr <= RESET_PC;
            r_squash    <= 1'b0;
            r_halted    <= 1'b0;
        end else if (redirect) begin
            r_state  <= ST_REQ;
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
            r_squash <= w_outstanding;
            if (w_outstanding & ~r_squash)
                r_hold_addr <= r_pc;
        end else begin
            if (r_squash & imem_ready)
                r_squash <= 1'b0;
            if (w_load)
                r_pc <= w_pc_next;
            case (r_state)
                ST_REQ: begin
                    if (w_misalign) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (w_load) begin
                        if (is_halt_opc(imem_rdata, HALT_OPC)) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_BUF;
                        end
                    end
                end
                ST_WAIT_BUF: begin
                    if (w_load) begin
                        if (is_halt_opc(imem_rdata, HALT_OPC)) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end else if (stall_n) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_REQ;
            endcase
        end
    end

    fetch_buf #(
        .NOP_INSTR (NOP_INSTR)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_consume (stall_n),
        .i_flush   (redirect),
        .i_instr   (imem_rdata),
        .i_pc_inc  (w_pc_next),
        .o_vld     (w_buf_vld),
        .o_instr   (instr),
        .o_pc_inc  (pc_inc)
    );

    assign halted      = r_halted;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, hold, squashed redirect,
// HALT, PC wrap and (macro-dependent) odd-PC behaviour.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        stall_n;
    logic        halted;
    logic        err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] mem_lat;
    logic [3:0] mem_cnt;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .pc_inc      (pc_inc),
        .stall_n     (stall_n),
        .halted      (halted),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    // Word at 0x0010 is HALT (opcode 0); elsewhere {1, addr[15:1]} (opcode never 0).
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010)
            return 16'h0000;
        return {1'b1, a[15:1]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)
            mem_cnt <= 4'd0;
        else if (!imem_req || imem_ready)
            mem_cnt <= 4'd0;
        else
            mem_cnt <= mem_cnt + 4'd1;
    end

    assign imem_ready = imem_req && (mem_cnt >= mem_lat);
    assign imem_rdata = mem_word(imem_addr);

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_instr [3];

    // ---------------- stimulus ----------------
    initial begin
        exp_instr[0] = 16'h8000;
        exp_instr[1] = 16'h8001;
        exp_instr[2] = 16'h8002;

        rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; mem_lat = 4'd0;
        next_cycle();
        next_cycle();
        check("rst_req",     {15'd0, imem_req}, 16'h0000);
        check("rst_instr",   instr,             16'h0800);
        check("rst_pc_inc",  pc_inc,            16'h0000);
        check("rst_stall_n", {15'd0, stall_n},  16'h0000);
        check("rst_halted",  {15'd0, halted},   16'h0000);
        check("rst_err",     {15'd0, err},      16'h0000);
        check("rst_state",   {14'd0, dbg_state}, 16'h0000);

        // 1: zero-latency sequential fetch
        rst = 1'b0;
        settle();
        check("t1_req0",  {15'd0, imem_req}, 16'h0001);
        check("t1_addr0", imem_addr,         16'h0000);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            check("t1_instr",   instr,            exp_instr[k]);
            check("t1_pc_inc",  pc_inc,           16'(2 * k + 2));
            check("t1_stall_n", {15'd0, stall_n}, 16'h0001);
        end

        // 2: hold with buffer full (word @4 buffered, pc=6)
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("t2_req",     {15'd0, imem_req}, 16'h0000);
            check("t2_instr",   instr,             16'h8002);
            check("t2_stall_n", {15'd0, stall_n},  16'h0000);
            next_cycle();
        end
        hold = 1'b0;
        settle();
        check("t2_rel_stall", {15'd0, stall_n}, 16'h0001);
        check("t2_rel_addr",  imem_addr,        16'h0006);
        next_cycle();
        settle();
        check("t2_next_instr", instr,  16'h8003);
        check("t2_next_pcinc", pc_inc, 16'h0008);

        // 3: 3-cycle latency, redirect on 2nd wait cycle squashes the read @8
        mem_lat = 4'd3;
        next_cycle();
        redirect = 1'b1; redirect_pc = 16'h0100;
        settle();
        check("t3_redir_stall", {15'd0, stall_n}, 16'h0000);
        next_cycle();
        redirect = 1'b0;
        settle();
        check("t3_hold_addr", imem_addr,        16'h0008);
        check("t3_sq_stall1", {15'd0, stall_n}, 16'h0000);
        next_cycle();
        settle();
        check("t3_sq_ready",  {15'd0, imem_ready}, 16'h0001);
        check("t3_sq_stall2", {15'd0, stall_n},    16'h0000);
        next_cycle();
        mem_lat = 4'd0;
        settle();
        check("t3_new_addr",  imem_addr,         16'h0100);
        check("t3_new_req",   {15'd0, imem_req}, 16'h0001);
        check("t3_sq_instr",  instr,             16'h0800);
        check("t3_sq_stall3", {15'd0, stall_n},  16'h0000);
        next_cycle();
        settle();
        check("t3_tgt_instr", instr,  16'h8080);
        check("t3_tgt_pcinc", pc_inc, 16'h0102);

        // 4: HALT word at 0x0010
        redirect = 1'b1; redirect_pc = 16'h0010;
        settle();
        check("t4_redir_req", {15'd0, imem_req}, 16'h0000);
        next_cycle();
        redirect = 1'b0;
        settle();
        check("t4_addr", imem_addr, 16'h0010);
        next_cycle();
        settle();
        check("t4_instr",   instr,             16'h0000);
        check("t4_pc_inc",  pc_inc,            16'h0012);
        check("t4_halted",  {15'd0, halted},   16'h0001);
        check("t4_req",     {15'd0, imem_req}, 16'h0000);
        check("t4_stall_n", {15'd0, stall_n},  16'h0001);
        check("t4_state",   {14'd0, dbg_state}, 16'h0002);
        next_cycle();
        settle();
        check("t4_idle_req",   {15'd0, imem_req}, 16'h0000);
        check("t4_idle_stall", {15'd0, stall_n},  16'h0000);
        check("t4_idle_instr", instr,             16'h0800);
        next_cycle();
        redirect = 1'b1; redirect_pc = 16'h0020;
        next_cycle();
        redirect = 1'b0;
        settle();
        check("t4_unhalt",     {15'd0, halted},   16'h0000);
        check("t4_resume_req", {15'd0, imem_req}, 16'h0001);
        check("t4_resume_adr", imem_addr,         16'h0020);
        next_cycle();
        settle();
        check("t4_resume_instr", instr,  16'h8010);
        check("t4_resume_pcinc", pc_inc, 16'h0022);

        // 5: PC wrap at 0xFFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        next_cycle();
        redirect = 1'b0;
        settle();
        check("t5_addr", imem_addr, 16'hFFFE);
        next_cycle();
        settle();
        check("t5_instr",     instr,     16'hFFFF);
        check("t5_pc_inc",    pc_inc,    16'h0000);
        check("t5_wrap_addr", imem_addr, 16'h0000);

        // 6: odd redirect target
        redirect = 1'b1; redirect_pc = 16'h0005;
        next_cycle();
        redirect = 1'b0;
        settle();
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_no_req", {15'd0, imem_req}, 16'h0000);
        next_cycle();
        settle();
        check("t6_err",     {15'd0, err},      16'h0001);
        check("t6_halted",  {15'd0, halted},   16'h0001);
        check("t6_req",     {15'd0, imem_req}, 16'h0000);
        redirect = 1'b1; redirect_pc = 16'h0040;
        next_cycle();
        redirect = 1'b0;
        settle();
        check("t6_unhalt",  {15'd0, halted},   16'h0000);
        check("t6_sticky",  {15'd0, err},      16'h0001);
        check("t6_addr40",  imem_addr,         16'h0040);
`else
        check("t6_odd_addr", imem_addr,         16'h0005);
        check("t6_odd_req",  {15'd0, imem_req}, 16'h0001);
        check("t6_err0",     {15'd0, err},      16'h0000);
        next_cycle();
        settle();
        check("t6_odd_instr", instr,           16'h8002);
        check("t6_odd_pcinc", pc_inc,          16'h0007);
        check("t6_err_still", {15'd0, err},    16'h0000);
`endif

        // reset in the middle of operation drops the request immediately
        rst = 1'b1;
        settle();
        check("rst_mid_req",   {15'd0, imem_req}, 16'h0000);
        check("rst_mid_instr", instr,             16'h0800);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
